// File: rtl/spi_bram_rd_arbiter.sv
// Round-robin burst-read arbiter for port B of the SPI receive BRAM.
// Each granted requester gets len+1 consecutive beats, returned tagged with its id and a last flag.
module spi_bram_rd_arbiter #(
    parameter  int NUM_REQ    = 2,
    parameter  int ADDR_WIDTH = 12,
    parameter  int DATA_WIDTH = 8,
    parameter  int RD_LATENCY = 1,
    localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ*8-1:0]          i_len,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic                          o_busy,
    output logic                          o_bram_enb,
    output logic [ADDR_WIDTH-1:0]         o_bram_addrb,
    input  logic [DATA_WIDTH-1:0]         i_bram_doutb,
    output logic                          o_rd_valid,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic                          o_rd_last,
    output logic [ID_WIDTH-1:0]           o_rd_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [ID_WIDTH-1:0]     ptr_r, ptr_s;
    logic [ID_WIDTH-1:0]     win_r, win_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic [7:0]              len_r, len_s;
    logic [7:0]              cnt_r, cnt_s;
    logic [NUM_REQ-1:0]      gnt_r, gnt_s;
    logic                    enb_r, enb_s;
    logic                    busy_r;
    logic                    found_s;
    logic [ID_WIDTH-1:0]     pick_s;
    logic                    issue_last_s;
    logic [RD_LATENCY:0]     vld_pipe_r;
    logic [RD_LATENCY:0]     last_pipe_r;
    logic [ID_WIDTH-1:0]     id_pipe_r [0:RD_LATENCY];
    logic [DATA_WIDTH-1:0]   data_r;

    // Round-robin search: first requester at or above ptr, wrapping around.
    always_comb begin
        int idx;
        found_s = 1'b0;
        pick_s  = '0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_r) + i) % NUM_REQ;
            if (!found_s && i_req[idx]) begin
                found_s = 1'b1;
                pick_s  = ID_WIDTH'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Beat issued this cycle is the final one of the burst.
    assign issue_last_s = enb_r && (cnt_r == len_r);

    // Next-state and registered-output decode.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        win_s   = win_r;
        addr_s  = addr_r;
        len_s   = len_r;
        cnt_s   = cnt_r;
        gnt_s   = '0;
        enb_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_s        = READ;
                    win_s          = pick_s;
                    addr_s         = i_addr[pick_s*ADDR_WIDTH +: ADDR_WIDTH];
                    len_s          = i_len[pick_s*8 +: 8];
                    cnt_s          = 8'd0;
                    gnt_s[pick_s]  = 1'b1;
                    enb_s          = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (cnt_r == len_r) begin
                    state_s = DRAIN;
                    ptr_s   = (win_r == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_r + 1'b1;
                end else begin
                    cnt_s  = cnt_r + 8'd1;
                    addr_s = addr_r + ADDR_WIDTH'(1);
                    enb_s  = 1'b1;
                end
            end
            DRAIN: begin
                // Leave one cycle early so IDLE coincides with the last returned beat.
                if (vld_pipe_r[RD_LATENCY-1] && last_pipe_r[RD_LATENCY-1]) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state, burst context and BRAM port registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            win_r   <= '0;
            addr_r  <= '0;
            len_r   <= 8'd0;
            cnt_r   <= 8'd0;
            gnt_r   <= '0;
            enb_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            win_r   <= win_s;
            addr_r  <= addr_s;
            len_r   <= len_s;
            cnt_r   <= cnt_s;
            gnt_r   <= gnt_s;
            enb_r   <= enb_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Return pipeline: tags follow the BRAM latency plus one output register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vld_pipe_r  <= '0;
            last_pipe_r <= '0;
            data_r      <= '0;
            for (int k = 0; k <= RD_LATENCY; k++) begin
                id_pipe_r[k] <= '0;
            end
        end else begin
            vld_pipe_r   <= {vld_pipe_r[RD_LATENCY-1:0], enb_r};
            last_pipe_r  <= {last_pipe_r[RD_LATENCY-1:0], issue_last_s};
            data_r       <= i_bram_doutb;
            id_pipe_r[0] <= win_r;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                id_pipe_r[k] <= id_pipe_r[k-1];
            end
        end
    end

    assign o_gnt        = gnt_r;
    assign o_busy       = busy_r;
    assign o_bram_enb   = enb_r;
    assign o_bram_addrb = addr_r;
    assign o_rd_valid   = vld_pipe_r[RD_LATENCY];
    assign o_rd_last    = vld_pipe_r[RD_LATENCY] & last_pipe_r[RD_LATENCY];
    assign o_rd_id      = id_pipe_r[RD_LATENCY];
    assign o_rd_data    = data_r;

endmodule

// File: tb/tb_spi_bram_rd_arbiter.sv
// Bench for spi_bram_rd_arbiter: two instances (read latency 1 and 2) against a
// transaction-level schedule model built from the arbitration and latency rules.
module tb_spi_bram_rd_arbiter;
    localparam int N  = 2;
    localparam int AW = 12;
    localparam int DW = 8;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [N-1:0]    req   [2];
    logic [N*AW-1:0] addr  [2];
    logic [N*8-1:0]  len   [2];
    logic [N-1:0]    gnt   [2];
    logic            busy  [2];
    logic            enb   [2];
    logic [AW-1:0]   addrb [2];
    logic [DW-1:0]   doutb [2];
    logic            rd_valid [2];
    logic [DW-1:0]   rd_data  [2];
    logic            rd_last  [2];
    logic [0:0]      rd_id    [2];

    logic [DW-1:0] mem [4096];
    logic [DW-1:0] stage2 = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ptr_m [2];
    int busy_n [2];
    logic mon [2];
    logic [63:0] og0[$], oe0[$], rq0[$];
    logic [63:0] og1[$], oe1[$], rq1[$];

    spi_bram_rd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_req(req[0]), .i_addr(addr[0]), .i_len(len[0]),
        .o_gnt(gnt[0]), .o_busy(busy[0]), .o_bram_enb(enb[0]), .o_bram_addrb(addrb[0]),
        .i_bram_doutb(doutb[0]), .o_rd_valid(rd_valid[0]), .o_rd_data(rd_data[0]),
        .o_rd_last(rd_last[0]), .o_rd_id(rd_id[0]));

    spi_bram_rd_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_req(req[1]), .i_addr(addr[1]), .i_len(len[1]),
        .o_gnt(gnt[1]), .o_busy(busy[1]), .o_bram_enb(enb[1]), .o_bram_addrb(addrb[1]),
        .i_bram_doutb(doutb[1]), .o_rd_valid(rd_valid[1]), .o_rd_data(rd_data[1]),
        .o_rd_last(rd_last[1]), .o_rd_id(rd_id[1]));

    // BRAM models: one-cycle and two-cycle read latency.
    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (enb[0]) doutb[0] <= mem[addrb[0]];
        if (enb[1]) stage2 <= mem[addrb[1]];
        doutb[1] <= stage2;
    end

    // Observation log, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (mon[0]) begin
            if (gnt[0] != '0) og0.push_back({32'(cyc), 32'(gnt[0])});
            if (enb[0]) oe0.push_back({32'(cyc), 20'd0, addrb[0]});
            if (rd_valid[0] || rd_last[0])
                rq0.push_back({32'(cyc), 8'(rd_id[0]), 8'({rd_valid[0], rd_last[0]}), 8'd0, rd_data[0]});
            if (busy[0]) busy_n[0]++;
        end
        if (mon[1]) begin
            if (gnt[1] != '0) og1.push_back({32'(cyc), 32'(gnt[1])});
            if (enb[1]) oe1.push_back({32'(cyc), 20'd0, addrb[1]});
            if (rd_valid[1] || rd_last[1])
                rq1.push_back({32'(cyc), 8'(rd_id[1]), 8'({rd_valid[1], rd_last[1]}), 8'd0, rd_data[1]});
            if (busy[1]) busy_n[1]++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input logic [63:0] o[$], input logic [63:0] e[$]);
        chk({tag, " count"}, 64'(o.size()), 64'(e.size()));
        for (int i = 0; i < e.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), (i < o.size()) ? o[i] : '1, e[i]);
    endtask

    task automatic clear_log(input int s);
        busy_n[s] = 0;
        if (s == 0) begin og0.delete(); oe0.delete(); rq0.delete(); end
        else begin og1.delete(); oe1.delete(); rq1.delete(); end
    endtask

    function automatic logic [63:0] outs(input int s);
        return 64'({gnt[s], busy[s], enb[s], addrb[s], rd_valid[s], rd_data[s], rd_last[s], rd_id[s]});
    endfunction

    // Raise the requests in mask, predict the full grant/issue/return schedule, run it, compare.
    task automatic run_scen(input int s, input logic [1:0] mask, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [7:0] l0, input logic [7:0] l1, input string tag);
        logic [AW-1:0] a [2];
        logic [7:0]    l [2];
        logic [63:0]   eg[$], ee[$], er[$];
        logic [1:0]    pend, drop;
        int rdl, c0, t, w, g, p, eb;
        a[0] = a0; a[1] = a1; l[0] = l0; l[1] = l1;
        rdl = s + 1;
        clear_log(s);
        mon[s] = 1'b1;
        @(posedge sys_clk); #1;
        addr[s] = {a1, a0};
        len[s]  = {l1, l0};
        req[s]  = mask;
        c0 = cyc;
        pend = mask; p = ptr_m[s]; t = c0; eb = 0;
        while (pend != 2'b00) begin
            w = -1;
            for (int i = 0; i < N; i++) if (w < 0 && pend[(p + i) % N]) w = (p + i) % N;
            g = t + 1;
            eg.push_back({32'(g), 32'(1 << w)});
            for (int b = 0; b <= int'(l[w]); b++) begin
                ee.push_back({32'(g + b), 20'd0, AW'(int'(a[w]) + b)});
                er.push_back({32'(g + b + rdl + 1), 8'(w), 8'((b == int'(l[w])) ? 3 : 2), 8'd0,
                              mem[AW'(int'(a[w]) + b)]});
            end
            eb += int'(l[w]) + rdl + 1;
            t = g + int'(l[w]) + rdl + 1;
            pend[w] = 1'b0;
            p = (w + 1) % N;
        end
        ptr_m[s] = p;
        drop = 2'b00;
        while (cyc <= t + 2) begin
            @(posedge sys_clk); #1;
            req[s] = req[s] & ~drop;
            drop = gnt[s];
        end
        req[s] = '0;
        mon[s] = 1'b0;
        if (s == 0) begin
            cmp_q({tag, " gnt"}, og0, eg); cmp_q({tag, " addrb"}, oe0, ee); cmp_q({tag, " rd"}, rq0, er);
        end else begin
            cmp_q({tag, " gnt"}, og1, eg); cmp_q({tag, " addrb"}, oe1, ee); cmp_q({tag, " rd"}, rq1, er);
        end
        chk({tag, " busy cycles"}, 64'(busy_n[s]), 64'(eb));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h010] = 8'hA0; mem[12'h011] = 8'hA1; mem[12'h012] = 8'hA2; mem[12'h013] = 8'hA3;
        for (int s = 0; s < 2; s++) begin
            req[s] = '0; addr[s] = '0; len[s] = '0; doutb[s] = '0;
            mon[s] = 1'b0; ptr_m[s] = 0; busy_n[s] = 0;
        end
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("reset outs lat1", outs(0), 64'd0);
        chk("reset outs lat2", outs(1), 64'd0);
        sys_rst_n = 1'b1;

        run_scen(0, 2'b11, 12'h300, 12'h400, 8'd0, 8'd0, "both_a");
        run_scen(0, 2'b11, 12'h310, 12'h410, 8'd0, 8'd0, "both_b");
        run_scen(0, 2'b01, 12'h010, 12'h000, 8'd3, 8'd0, "req0_len3");
        run_scen(0, 2'b10, 12'h000, 12'hFFE, 8'd0, 8'd3, "req1_wrap");
        run_scen(0, 2'b01, 12'hF80, 12'h000, 8'd255, 8'd0, "len256");
        for (int k = 0; k < 10; k++)
            run_scen(0, 2'($urandom_range(1, 3)), AW'($urandom), AW'($urandom),
                     8'($urandom_range(0, 9)), 8'($urandom_range(0, 9)), $sformatf("rnd%0d", k));

        begin : mid_burst_reset
            int c0;
            clear_log(0);
            @(posedge sys_clk); #1;
            addr[0] = {12'h000, 12'h100};
            len[0]  = {8'd0, 8'd15};
            req[0]  = 2'b01;
            c0 = cyc;
            @(posedge sys_clk); #1;
            chk("rst_mid gnt", 64'(gnt[0]), 64'd1);
            @(posedge sys_clk); #1;
            req[0] = '0;
            repeat (4) begin @(posedge sys_clk); #1; end
            chk("rst_mid beat5 cycle", 64'(cyc - c0), 64'd6);
            chk("rst_mid beat5 addrb", 64'({enb[0], addrb[0]}), 64'({1'b1, 12'h105}));
            #2 sys_rst_n = 1'b0;
            #1;
            chk("rst_mid async clear", outs(0), 64'd0);
            repeat (2) @(posedge sys_clk);
            #1;
            sys_rst_n = 1'b1;
            ptr_m[0] = 0; ptr_m[1] = 0;
            clear_log(0);
            mon[0] = 1'b1;
            repeat (10) begin @(posedge sys_clk); #1; end
            mon[0] = 1'b0;
            chk("rst_mid no valid", 64'(rq0.size()), 64'd0);
            chk("rst_mid no enb", 64'(oe0.size()), 64'd0);
            chk("rst_mid not busy", 64'(busy_n[0]), 64'd0);
        end
        run_scen(0, 2'b10, 12'h000, 12'h555, 8'd0, 8'd4, "after_rst");

        run_scen(1, 2'b01, 12'h200, 12'h000, 8'd1, 8'd0, "lat2_single");
        run_scen(1, 2'b11, 12'h210, 12'h220, 8'd1, 8'd1, "lat2_b2b");
        run_scen(1, 2'b11, 12'hFFF, 12'h7F0, 8'd2, 8'd0, "lat2_wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
